// File: rtl/shifter_pkg.sv
// Shared op encodings for the pipelined barrel shifter.
// Optional flag outputs are enabled with SHIFTER_FLAGS_EN.
package shifter_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b10;
  localparam shift_op_t OP_ROL = 2'b11;

endpackage

// File: rtl/shift_level.sv
// One barrel-shifter mux level shifting by a fixed DIST when enabled.
// The carry port exists only when SHIFTER_FLAGS_EN is defined.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  shift_op_t        op,
  input  logic             en,
  output logic [WIDTH-1:0] data_out
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             carry
`endif
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_in;
    unique case (op)
      OP_SLL: shifted = data_in << DIST;
      OP_SRL: shifted = data_in >> DIST;
      OP_SRA: shifted = $signed(data_in) >>> DIST;
      OP_ROL: shifted = {data_in[WIDTH-DIST-1:0],
                         data_in[WIDTH-1:WIDTH-DIST]};
    endcase
  end

  assign data_out = en ? shifted : data_in;

`ifdef SHIFTER_FLAGS_EN
  // Rotate reports the bit that wrapped into bit 0.
  assign carry = (op == OP_SRL || op == OP_SRA) ?
                 data_in[DIST-1] : data_in[WIDTH-DIST];
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready and tag.
// Define SHIFTER_FLAGS_EN to add the out_zero/out_carry flag outputs.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH            = 32,
  parameter  int LEVELS_PER_STAGE = 1,
  parameter  int TAG_W            = 4,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int NSTAGES =
    (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  shift_op_t          in_op,
  input  logic [WIDTH-1:0]   in_target,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_carry
`endif
);

  logic [NSTAGES-1:0] v_q;
  logic [NSTAGES-1:0] src_v;
  logic [NSTAGES-1:0] ld;
  logic [WIDTH-1:0]   d_q     [NSTAGES];
  logic [WIDTH-1:0]   d_nx    [NSTAGES];
  shift_op_t          op_q    [NSTAGES];
  shift_op_t          src_op  [NSTAGES];
  logic [SHAMT_W-1:0] sh_q    [NSTAGES];
  logic [SHAMT_W-1:0] src_sh  [NSTAGES];
  logic [TAG_W-1:0]   tag_q   [NSTAGES];
  logic [TAG_W-1:0]   src_tag [NSTAGES];
`ifdef SHIFTER_FLAGS_EN
  logic [NSTAGES-1:0] c_q;
  logic [NSTAGES-1:0] c_nx;
  logic               z_q;
`endif

  // A stage may load if out_ready or any stage at or after it is empty.
  always_comb begin
    ld = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      ld[k] = out_ready;
      for (int m = k; m < NSTAGES; m++)
        if (!v_q[m]) ld[k] = 1'b1;
    end
  end

  for (genvar s = 0; s < NSTAGES; s++) begin : g_st
    logic [WIDTH-1:0] d [LEVELS_PER_STAGE+1];
`ifdef SHIFTER_FLAGS_EN
    logic c [LEVELS_PER_STAGE+1];
`endif
    if (s == 0) begin : g_in
      assign src_v[s]   = in_valid;
      assign src_op[s]  = in_op;
      assign src_sh[s]  = in_shamt;
      assign src_tag[s] = in_tag;
      assign d[0]       = in_target;
`ifdef SHIFTER_FLAGS_EN
      assign c[0]       = 1'b0;
`endif
    end else begin : g_up
      assign src_v[s]   = v_q[s-1];
      assign src_op[s]  = op_q[s-1];
      assign src_sh[s]  = sh_q[s-1];
      assign src_tag[s] = tag_q[s-1];
      assign d[0]       = d_q[s-1];
`ifdef SHIFTER_FLAGS_EN
      assign c[0]       = c_q[s-1];
`endif
    end
    for (genvar l = 0; l < LEVELS_PER_STAGE; l++) begin : g_lv
      localparam int J = s * LEVELS_PER_STAGE + l;
      if (J < SHAMT_W) begin : g_mux
`ifdef SHIFTER_FLAGS_EN
        logic lc;
`endif
        shift_level #(
          .WIDTH(WIDTH),
          .DIST (1 << J)
        ) u_lvl (
          .data_in (d[l]),
          .op      (src_op[s]),
          .en      (src_sh[s][J]),
          .data_out(d[l+1])
`ifdef SHIFTER_FLAGS_EN
          ,
          .carry   (lc)
`endif
        );
`ifdef SHIFTER_FLAGS_EN
        assign c[l+1] = src_sh[s][J] ? lc : c[l];
`endif
      end else begin : g_pass
        assign d[l+1] = d[l];
`ifdef SHIFTER_FLAGS_EN
        assign c[l+1] = c[l];
`endif
      end
    end
    assign d_nx[s] = d[LEVELS_PER_STAGE];
`ifdef SHIFTER_FLAGS_EN
    assign c_nx[s] = c[LEVELS_PER_STAGE];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        d_q[k]   <= '0;
        op_q[k]  <= OP_SLL;
        sh_q[k]  <= '0;
        tag_q[k] <= '0;
      end
`ifdef SHIFTER_FLAGS_EN
      c_q <= '0;
      z_q <= 1'b1;
`endif
    end else begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (ld[k]) v_q[k] <= src_v[k];
        if (ld[k] && src_v[k]) begin
          d_q[k]   <= d_nx[k];
          op_q[k]  <= src_op[k];
          sh_q[k]  <= src_sh[k];
          tag_q[k] <= src_tag[k];
`ifdef SHIFTER_FLAGS_EN
          c_q[k]   <= c_nx[k];
`endif
        end
      end
`ifdef SHIFTER_FLAGS_EN
      if (ld[NSTAGES-1] && src_v[NSTAGES-1])
        z_q <= (d_nx[NSTAGES-1] == '0);
`endif
    end
  end

  assign in_ready   = ld[0];
  assign out_valid  = v_q[NSTAGES-1];
  assign out_result = d_q[NSTAGES-1];
  assign out_tag    = tag_q[NSTAGES-1];
`ifdef SHIFTER_FLAGS_EN
  assign out_zero   = z_q;
  assign out_carry  = c_q[NSTAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: 32-bit/1-level and 16-bit/2-level builds.
// Flag checks are included when SHIFTER_FLAGS_EN is defined.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   acc = 0;
  int   acc_cnt = 0;

  logic        a_iv, a_ir, a_ov, a_or;
  shift_op_t   a_op;
  logic [31:0] a_x, a_res;
  logic [4:0]  a_sh;
  logic [3:0]  a_tag, a_otag;
  logic        b_iv, b_ir, b_ov, b_or;
  shift_op_t   b_op;
  logic [15:0] b_x, b_res;
  logic [3:0]  b_sh;
  logic [3:0]  b_tag, b_otag;
`ifdef SHIFTER_FLAGS_EN
  logic a_z, a_c, b_z, b_c;
`endif

  pipelined_shifter u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_op(a_op),
    .in_target(a_x), .in_shamt(a_sh), .in_tag(a_tag),
    .out_valid(a_ov), .out_ready(a_or),
    .out_result(a_res), .out_tag(a_otag)
`ifdef SHIFTER_FLAGS_EN
    , .out_zero(a_z), .out_carry(a_c)
`endif
  );

  pipelined_shifter #(.WIDTH(16), .LEVELS_PER_STAGE(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_op(b_op),
    .in_target(b_x), .in_shamt(b_sh), .in_tag(b_tag),
    .out_valid(b_ov), .out_ready(b_or),
    .out_result(b_res), .out_tag(b_otag)
`ifdef SHIFTER_FLAGS_EN
    , .out_zero(b_z), .out_carry(b_c)
`endif
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain shift arithmetic on a w-bit value.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] xi,
                                 input int sh, input int w,
                                 input logic [3:0] tag);
    logic [31:0] m, r, x;
    exp_t e;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    x = xi & m;
    case (op)
      2'd0:    r = (x << sh) & m;
      2'd1:    r = x >> sh;
      2'd2:    r = (x >> sh) | (x[w-1] ? (m & ~(m >> sh)) : 32'd0);
      default: r = ((x << sh) | (x >> (w - sh))) & m;
    endcase
    e.res = r;
    e.tag = tag;
    if (sh == 0)      e.c = 1'b0;
    else if (op == 0) e.c = x[w-sh];
    else if (op == 3) e.c = r[0];
    else              e.c = x[sh-1];
    return e;
  endfunction

  initial begin : mon_a
    logic held;
    logic [31:0] pr;
    logic [3:0] pt;
    held = 1'b0; pr = '0; pt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        qa.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          chk("a_hold_res", a_res, pr);
          chk("a_hold_tag", a_otag, pt);
        end
        if (a_ov) begin
          if (qa.size() == 0) chk("a_extra_out", a_ov, 0);
          else begin
            chk("a_res", a_res, qa[0].res);
            chk("a_tag", a_otag, qa[0].tag);
`ifdef SHIFTER_FLAGS_EN
            chk("a_carry", a_c, qa[0].c);
            chk("a_zero", a_z, qa[0].res == 0);
`endif
            if (a_or) void'(qa.pop_front());
          end
        end
        if (a_iv && a_ir) qa.push_back(model(a_op, a_x, int'(a_sh), 32, a_tag));
        held = a_ov && !a_or;
        pr = a_res;
        pt = a_otag;
      end
    end
  end

  initial begin : mon_b
    logic held;
    logic [15:0] pr;
    logic [3:0] pt;
    held = 1'b0; pr = '0; pt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        qb.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          chk("b_hold_res", b_res, pr);
          chk("b_hold_tag", b_otag, pt);
        end
        if (b_ov) begin
          if (qb.size() == 0) chk("b_extra_out", b_ov, 0);
          else begin
            chk("b_res", b_res, qb[0].res);
            chk("b_tag", b_otag, qb[0].tag);
`ifdef SHIFTER_FLAGS_EN
            chk("b_carry", b_c, qb[0].c);
            chk("b_zero", b_z, qb[0].res == 0);
`endif
            if (b_or) void'(qb.pop_front());
          end
        end
        if (b_iv && b_ir)
          qb.push_back(model(b_op, {16'h0, b_x}, int'(b_sh), 16, b_tag));
        held = b_ov && !b_or;
        pr = b_res;
        pt = b_otag;
      end
    end
  end

  task automatic send_a(input shift_op_t op, input logic [31:0] x,
                        input int sh, input logic [3:0] tag);
    int n;
    n = 0;
    a_iv = 1'b1; a_op = op; a_x = x; a_sh = 5'(sh); a_tag = tag;
    @(negedge clk);
    while (!a_ir && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept", a_ir, 1);
    acc = cyc;
    acc_cnt++;
    @(posedge clk);
    #1 a_iv = 1'b0;
  endtask

  task automatic wait_a;
    int n;
    n = 0;
    @(negedge clk);
    while (!a_ov && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("a_out_wait", a_ov, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    a_iv = 0; a_or = 1; a_op = OP_SLL; a_x = 0; a_sh = 0; a_tag = 0;
    b_iv = 0; b_or = 1; b_op = OP_SLL; b_x = 0; b_sh = 0; b_tag = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_in_ready", a_ir, 1);
    chk("rst_result", a_res, 0);
    chk("rst_tag", a_otag, 0);
    chk("rst_b_valid", b_ov, 0);
`ifdef SHIFTER_FLAGS_EN
    chk("rst_zero", a_z, 1);
    chk("rst_carry", a_c, 0);
`endif
    @(posedge clk); #1;

    send_a(OP_SLL, 32'h0000_0001, 31, 4'd3);
    wait_a();
    chk("sll31_latency", cyc - acc, 5);
    chk("sll31_res", a_res, 32'h8000_0000);
    chk("sll31_tag", a_otag, 3);
    @(posedge clk); #1;

    send_a(OP_SRA, 32'h8000_0000, 4, 4'd1);
    send_a(OP_SRL, 32'h8000_0000, 4, 4'd2);
    send_a(OP_ROL, 32'h8000_0001, 1, 4'd3);
    wait_a();
    chk("sra_res", a_res, 32'hF800_0000);
    @(negedge clk);
    chk("srl_valid", a_ov, 1);
    chk("srl_res", a_res, 32'h0800_0000);
    @(negedge clk);
    chk("rol_valid", a_ov, 1);
    chk("rol_res", a_res, 32'h0000_0003);
    @(posedge clk); #1;

    a_or = 1'b0;
    acc_cnt = 0;
    fork
      for (int t = 0; t < 16; t++)
        send_a(shift_op_t'(t), 32'h8000_0001 ^ (32'h0101_0101 * t),
               (t * 7) % 32, 4'(t));
      begin
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        chk("bp_accepts", acc_cnt, 5);
        chk("bp_in_ready", a_ir, 0);
        @(posedge clk);
        #1 a_or = 1'b1;
      end
    join
    n = 0;
    while (qa.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_drained", qa.size(), 0);
    @(posedge clk); #1;

    send_a(OP_SLL, 32'h1234_5678, 3, 4'd7);
    send_a(OP_SRA, 32'hF000_000F, 9, 4'd8);
    send_a(OP_ROL, 32'h0000_FFFF, 17, 4'd9);
    rst = 1'b1;
    a_iv = 1'b1; a_op = OP_SRL; a_x = 32'hFFFF_FFFF; a_sh = 5'd1;
    @(posedge clk);
    #1 rst = 1'b0;
    a_iv = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", a_ov, 0);
    chk("mid_rst_ready", a_ir, 1);
    chk("mid_rst_result", a_res, 0);
    repeat (10) begin
      @(negedge clk);
      chk("mid_rst_flushed", a_ov, 0);
    end
    @(posedge clk); #1;

`ifdef SHIFTER_FLAGS_EN
    send_a(OP_SLL, 32'h8000_0000, 1, 4'd5);
    wait_a();
    chk("flag_sll_res", a_res, 0);
    chk("flag_sll_zero", a_z, 1);
    chk("flag_sll_carry", a_c, 1);
    @(posedge clk); #1;
    send_a(OP_SRL, 32'h0000_0006, 2, 4'd6);
    wait_a();
    chk("flag_srl_res", a_res, 32'h1);
    chk("flag_srl_zero", a_z, 0);
    chk("flag_srl_carry", a_c, 1);
    @(posedge clk); #1;
`endif

    b_iv = 1'b1; b_op = OP_ROL; b_x = 16'h8001; b_sh = 4'd4; b_tag = 4'd9;
    @(negedge clk);
    chk("b_accept", b_ir, 1);
    acc = cyc;
    @(posedge clk);
    #1 b_iv = 1'b0;
    n = 0;
    @(negedge clk);
    while (!b_ov && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_latency", cyc - acc, 2);
    chk("b_rol_res", b_res, 16'h0018);
    @(posedge clk); #1;

    for (int i = 0; i < 10000; i++) begin
      b_iv  = ($urandom_range(0, 3) != 0);
      b_op  = shift_op_t'($urandom_range(0, 3));
      b_x   = 16'($urandom);
      b_sh  = 4'($urandom_range(0, 15));
      b_tag = 4'(i);
      b_or  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
